superh16_icache_fill_ctrl: RTL and testbench

- Miss/fill sequencer for the L1 instruction cache (96KB, 6-way, 64B lines, 256 sets).
- Arbitrates the single L2 refill channel between demand misses and next-line prefetch requests, keeps one miss outstanding, and selects the victim way per set (round-robin).
- Drives the cache array fill write port, and sits between the I-cache tag/data arrays and the L2 interface.

---
 rtl/superh16_icache_fill_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_superh16_icache_fill_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/superh16_icache_fill_ctrl.sv
// L1 I-cache miss/fill sequencer: one outstanding L2 refill shared by demand
// misses and next-line prefetches, with a per-set round-robin victim pointer.
module superh16_icache_fill_ctrl #(
  parameter int ADDR_WIDTH = 48,
  parameter int NUM_WAYS   = 6,
  parameter int NUM_SETS   = 256,
  parameter int LINE_BITS  = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_dmd_valid,
  input  logic [ADDR_WIDTH-1:0]       i_dmd_addr,
  output logic                        o_dmd_ready,
  input  logic                        i_pf_valid,
  input  logic [ADDR_WIDTH-1:0]       i_pf_addr,
  output logic                        o_pf_ready,
  input  logic                        i_flush,
  output logic                        o_l2_req,
  output logic [ADDR_WIDTH-1:0]       o_l2_addr,
  input  logic                        i_l2_ack,
  input  logic [LINE_BITS-1:0]        i_l2_data,
  output logic                        o_fill_valid,
  output logic [$clog2(NUM_SETS)-1:0] o_fill_index,
  output logic [2:0]                  o_fill_way,
  output logic [ADDR_WIDTH-15:0]      o_fill_tag,
  output logic [LINE_BITS-1:0]        o_fill_data,
  output logic                        o_dmd_done,
  output logic                        o_busy
);

  localparam int OFF_W = 6;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [2:0] LAST_WAY = 3'(NUM_WAYS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_line_addr;
  logic                    r_is_dmd;
  logic                    r_kill;
  logic [2:0]              r_rr_ptr [NUM_SETS];
  logic                    r_l2_req;
  logic                    r_busy;
  logic                    r_fill_valid;
  logic                    r_dmd_done;
  logic [IDX_W-1:0]        r_fill_index;
  logic [2:0]              r_fill_way;
  logic [ADDR_WIDTH-15:0]  r_fill_tag;
  logic [LINE_BITS-1:0]    r_fill_data;

  logic                    w_dmd_ready;
  logic                    w_pf_ready;
  logic                    w_promo;
  logic                    w_kill_eff;
  logic                    w_dmd_acc;
  logic                    w_pf_acc;
  logic [ADDR_WIDTH-1:0]   w_acc_line;
  logic [IDX_W-1:0]        w_idx;
  logic [2:0]              w_cur_ptr;

  assign w_idx     = r_line_addr[OFF_W +: IDX_W];
  assign w_cur_ptr = r_rr_ptr[w_idx];

  // A pending prefetch is upgraded when a demand for the same line shows up; flush beats it.
  assign w_promo = (r_state == S_WAIT) & ~r_is_dmd & i_dmd_valid & ~i_flush &
                   ((i_dmd_addr & ~OFF_MASK) == r_line_addr);
  assign w_kill_eff = (r_kill | i_flush) & ~w_promo;

  // Handshake readiness: demand has strict priority, flush blocks acceptance in IDLE.
  always_comb begin
    w_dmd_ready = 1'b0;
    w_pf_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dmd_ready = ~i_flush;
        w_pf_ready  = ~i_flush & ~i_dmd_valid;
      end
      S_WAIT: begin
        w_dmd_ready = w_promo;
        w_pf_ready  = 1'b0;
      end
      default: begin
        w_dmd_ready = 1'b0;
        w_pf_ready  = 1'b0;
      end
    endcase
  end

  assign w_dmd_acc  = (r_state == S_IDLE) & i_dmd_valid & w_dmd_ready;
  assign w_pf_acc   = (r_state == S_IDLE) & i_pf_valid & w_pf_ready;
  assign w_acc_line = (w_dmd_acc ? i_dmd_addr : i_pf_addr) & ~OFF_MASK;

  // Sequencer state, victim pointers and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_line_addr  <= '0;
      r_is_dmd     <= 1'b0;
      r_kill       <= 1'b0;
      r_l2_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_fill_valid <= 1'b0;
      r_dmd_done   <= 1'b0;
      r_fill_index <= '0;
      r_fill_way   <= 3'd0;
      r_fill_tag   <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_rr_ptr[s] <= 3'd0;
    end else begin
      r_fill_valid <= 1'b0;
      r_dmd_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dmd_acc | w_pf_acc) begin
            r_line_addr <= w_acc_line;
            r_is_dmd    <= w_dmd_acc;
            r_kill      <= 1'b0;
            r_l2_req    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          r_is_dmd <= r_is_dmd | w_promo;
          if (i_l2_ack) begin
            r_l2_req <= 1'b0;
            r_kill   <= 1'b0;
            if (w_kill_eff) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_fill_valid <= 1'b1;
              r_dmd_done   <= r_is_dmd | w_promo;
              r_fill_index <= w_idx;
              r_fill_tag   <= r_line_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
              r_fill_way   <= w_cur_ptr;
              r_state      <= S_FILL;
            end
          end else begin
            r_kill <= w_kill_eff;
          end
        end
        S_FILL: begin
          r_rr_ptr[w_idx] <= (w_cur_ptr == LAST_WAY) ? 3'd0 : w_cur_ptr + 3'd1;
          r_busy          <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_l2_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Refill data holding register; its reset value is never observed.
  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT) && i_l2_ack && !w_kill_eff) r_fill_data <= i_l2_data;
  end

  assign o_dmd_ready  = w_dmd_ready;
  assign o_pf_ready   = w_pf_ready;
  assign o_l2_req     = r_l2_req;
  assign o_l2_addr    = r_line_addr;
  assign o_fill_valid = r_fill_valid;
  assign o_fill_index = r_fill_index;
  assign o_fill_way   = r_fill_way;
  assign o_fill_tag   = r_fill_tag;
  assign o_fill_data  = r_fill_data;
  assign o_dmd_done   = r_dmd_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_superh16_icache_fill_ctrl.sv
// Scoreboard bench for the I-cache fill sequencer: directed scenarios followed
// by randomized traffic, checked against a transaction-level reference model.
module tb_superh16_icache_fill_ctrl;

  localparam int AW = 48;
  localparam int LB = 512;
  localparam int P_IDLE = 0, P_WAIT = 1, P_FILL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_dmd_valid, i_pf_valid, i_flush, i_l2_ack;
  logic [AW-1:0] i_dmd_addr, i_pf_addr;
  logic [LB-1:0] i_l2_data;
  logic          o_dmd_ready, o_pf_ready, o_l2_req, o_fill_valid, o_dmd_done, o_busy;
  logic [AW-1:0] o_l2_addr;
  logic [7:0]    o_fill_index;
  logic [2:0]    o_fill_way;
  logic [33:0]   o_fill_tag;
  logic [LB-1:0] o_fill_data;

  superh16_icache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_dmd_valid(i_dmd_valid), .i_dmd_addr(i_dmd_addr), .o_dmd_ready(o_dmd_ready),
    .i_pf_valid(i_pf_valid), .i_pf_addr(i_pf_addr), .o_pf_ready(o_pf_ready),
    .i_flush(i_flush), .o_l2_req(o_l2_req), .o_l2_addr(o_l2_addr),
    .i_l2_ack(i_l2_ack), .i_l2_data(i_l2_data),
    .o_fill_valid(o_fill_valid), .o_fill_index(o_fill_index), .o_fill_way(o_fill_way),
    .o_fill_tag(o_fill_tag), .o_fill_data(o_fill_data),
    .o_dmd_done(o_dmd_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    idx;
    logic [2:0]    way;
    logic [33:0]   tag;
    logic [LB-1:0] data;
    logic          done;
    int            at;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one outstanding line plus a count of completed fills per set.
  int            m_phase;
  logic [AW-1:0] m_line;
  bit            m_isd, m_kill;
  int            m_fills [256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_line  = '0;
    m_isd   = 1'b0;
    m_kill  = 1'b0;
    foreach (m_fills[s]) m_fills[s] = 0;
    sb.delete();
  endtask

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] d;
    for (int k = 0; k < LB / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    int            sel;
    a        = '0;
    a[5:0]   = 6'($urandom_range(0, 63));
    a[17:14] = 4'($urandom_range(0, 3));
    sel      = $urandom_range(0, 3);
    a[13:6]  = (sel == 0) ? 8'h10 : (sel == 1) ? 8'h11 : 8'($urandom_range(0, 255));
    return a;
  endfunction

  // One clock of stimulus: drive, check handshake/level outputs, advance the model.
  task automatic step(input logic dv, input logic [AW-1:0] da, input logic pv,
                      input logic [AW-1:0] pa, input logic fl, input logic ack,
                      input logic [LB-1:0] d);
    bit   e_dr, e_pr, promo, killnow;
    exp_t e;
    @(negedge clk);
    i_dmd_valid = dv; i_dmd_addr = da; i_pf_valid = pv; i_pf_addr = pa;
    i_flush = fl; i_l2_ack = ack; i_l2_data = d;
    #1;
    e_dr = 1'b0;
    e_pr = 1'b0;
    if (m_phase == P_IDLE) begin
      e_dr = !fl;
      e_pr = !fl && !dv;
    end else if (m_phase == P_WAIT) begin
      e_dr = !m_isd && dv && !fl && ((da >> 6) == (m_line >> 6));
    end
    chk("dmd_ready", 64'(o_dmd_ready), 64'(e_dr));
    chk("pf_ready", 64'(o_pf_ready), 64'(e_pr));
    chk("l2_req", 64'(o_l2_req), 64'(m_phase == P_WAIT));
    chk("busy", 64'(o_busy), 64'(m_phase != P_IDLE));
    if (m_phase == P_WAIT) chk("l2_addr", 64'(o_l2_addr), 64'(m_line));

    case (m_phase)
      P_IDLE: begin
        if ((dv && e_dr) || (pv && e_pr)) begin
          m_line  = ((dv && e_dr) ? da : pa) & ~48'h3F;
          m_isd   = dv && e_dr;
          m_kill  = 1'b0;
          m_phase = P_WAIT;
        end
      end
      P_WAIT: begin
        promo   = e_dr;
        m_isd   = m_isd || promo;
        killnow = (m_kill || fl) && !promo;
        if (ack) begin
          m_kill = 1'b0;
          if (killnow) begin
            m_phase = P_IDLE;
          end else begin
            e.idx  = m_line[13:6];
            e.way  = 3'(m_fills[m_line[13:6]] % 6);
            e.tag  = m_line[47:14];
            e.data = d;
            e.done = m_isd;
            e.at   = cyc + 1;
            sb.push_back(e);
            m_fills[m_line[13:6]]++;
            m_phase = P_FILL;
          end
        end else begin
          m_kill = killnow;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Accept a demand, acknowledge it next cycle, and return with the fill visible.
  task automatic do_fill(input logic [AW-1:0] a);
    step(1'b1, a, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    idle_step();
  endtask

  // Monitor: every array write strobe must match the oldest expected fill.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_fill_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_fill", 64'(o_fill_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("fill_cycle", 64'(cyc), 64'(e.at));
        chk("fill_index", 64'(o_fill_index), 64'(e.idx));
        chk("fill_way", 64'(o_fill_way), 64'(e.way));
        chk("fill_tag", 64'(o_fill_tag), 64'(e.tag));
        chk("dmd_done", 64'(o_dmd_done), 64'(e.done));
        n_vec++;
        if (o_fill_data !== e.data) begin
          n_err++;
          $display("FAIL fill_data: got %0h expected %0h", o_fill_data[63:0], e.data[63:0]);
        end
      end
    end else if (rst_n && o_dmd_done) begin
      chk("dmd_done_no_fill", 64'(o_dmd_done), 64'd0);
    end
  end

  initial begin
    logic [LB-1:0] d0;
    logic          dv, pv, fl, ack;
    logic [AW-1:0] da;
    rst_n = 1'b0;
    i_dmd_valid = 1'b0; i_pf_valid = 1'b0; i_flush = 1'b0; i_l2_ack = 1'b0;
    i_dmd_addr = '0; i_pf_addr = '0; i_l2_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_l2_req", 64'(o_l2_req), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_fill_valid", 64'(o_fill_valid), 64'd0);
    chk("rst_dmd_done", 64'(o_dmd_done), 64'd0);
    chk("rst_l2_addr", 64'(o_l2_addr), 64'd0);
    chk("rst_fill_index", 64'(o_fill_index), 64'd0);
    chk("rst_fill_way", 64'(o_fill_way), 64'd0);
    chk("rst_fill_tag", 64'(o_fill_tag), 64'd0);
    rst_n = 1'b1;

    // Plain demand miss with a 5-cycle L2 latency.
    d0 = rnd_line();
    step(1'b1, 48'h0000_1234_5678, 1'b0, '0, 1'b0, 1'b0, '0);
    idle_step();
    chk("dir_l2_addr", 64'(o_l2_addr), 64'h0000_1234_5640);
    repeat (3) idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, d0);
    idle_step();
    chk("dir_fill_valid", 64'(o_fill_valid), 64'd1);
    chk("dir_fill_index", 64'(o_fill_index), 64'h59);
    chk("dir_fill_way", 64'(o_fill_way), 64'd0);
    chk("dir_dmd_done", 64'(o_dmd_done), 64'd1);

    // Demand and prefetch together: demand first, prefetch retried afterwards.
    step(1'b1, 48'h0000_0000_2000, 1'b1, 48'h0000_0000_2040, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 48'h0000_0000_2040, 1'b0, 1'b1, rnd_line());
    step(1'b0, '0, 1'b1, 48'h0000_0000_2040, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 48'h0000_0000_2040, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    idle_step();
    chk("pf_fill_no_done", 64'(o_dmd_done), 64'd0);

    // Prefetch promoted by a demand to the same line.
    step(1'b0, '0, 1'b1, 48'h0000_0000_4000, 1'b0, 1'b0, '0);
    step(1'b1, 48'h0000_0000_4010, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    idle_step();
    chk("promo_dmd_done", 64'(o_dmd_done), 64'd1);

    // Flush while waiting: response is dropped and the victim pointer holds.
    step(1'b1, 48'h0000_0000_8040, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    idle_step();
    chk("flush_no_fill", 64'(o_fill_valid), 64'd0);
    do_fill(48'h0000_0000_8040);
    chk("flush_way_kept", 64'(o_fill_way), 64'd0);

    // Seven fills to set 0x10 cycle through all ways; set 0x11 has its own pointer.
    for (int i = 0; i < 7; i++) begin
      do_fill(48'h0000_0001_0400 + 48'(i) * 48'h4000);
      chk("rr_seq", 64'(o_fill_way), 64'(i % 6));
      if (i == 3) begin
        do_fill(48'h0000_0000_0440);
        chk("rr_other_set", 64'(o_fill_way), 64'd0);
      end
    end

    // Asynchronous reset while waiting, then a stale acknowledge.
    step(1'b1, 48'h0000_0000_0400, 1'b0, '0, 1'b0, 1'b0, '0);
    idle_step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_l2_req", 64'(o_l2_req), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    idle_step();
    chk("late_ack_no_fill", 64'(o_fill_valid), 64'd0);
    do_fill(48'h0000_0000_0400);
    chk("post_rst_way", 64'(o_fill_way), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      dv  = ($urandom_range(0, 99) < 40);
      da  = (m_phase == P_WAIT && $urandom_range(0, 1) == 1) ?
            (m_line | 48'($urandom_range(0, 63))) : rnd_addr();
      pv  = ($urandom_range(0, 99) < 40);
      fl  = ($urandom_range(0, 99) < 6);
      ack = ($urandom_range(0, 99) < 35);
      step(dv, da, pv, rnd_addr(), fl, ack, rnd_line());
    end
    repeat (4) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rnd_line());
    repeat (2) idle_step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
